mac_acc_int8: RTL and testbench
===============================

MAC_ACC_INT8 -- requirements
Module: mac_acc_int8

Interface
REQ-001 Parameter ACC_W, default 32: accumulator and result width in bits, legal range 18..48.
REQ-002 Parameter CNT_W, default 16: beat-count width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1: input beat valid.
REQ-006 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 Port in_rs1, input, 9: signed activation, zero-point-adjusted.
REQ-008 Port in_rs2, input, 8: signed weight.
REQ-009 Port in_last, input, 1: beat closes the current dot product.
REQ-010 Port out_valid, output, 1: result valid.
REQ-011 Port out_ready, input, 1: downstream accepts the result.
REQ-012 Port out_acc, output, ACC_W: signed dot-product result.
REQ-013 Port out_cnt, output, CNT_W: number of beats in the result.
REQ-014 Port out_ovf, output, 1: signed overflow occurred at least once in this result.

Function
REQ-015 The block SHALL form each product with one instance of mul_int8 (rs1=in_rs1, rs2=in_rs2); the 17-bit output is the two's-complement value of signed(in_rs1)*signed(in_rs2).
REQ-016 Handshake: a beat transfers when in_valid and in_ready are both 1; a result transfers when out_valid and out_ready are both 1; in_* values are ignored when in_valid is 0.
REQ-017 Stage P: on transfer, register product (17b), last flag and valid bit p_valid.
REQ-018 Stage A: when p_valid is 1 and the stall condition is false, acc_sum = (first ? 0 : acc) + sign_extend(product), where first marks the first beat after reset or after a last.
REQ-019 Stall condition: p_last is 1, out_valid is 1 and out_ready is 0.
REQ-020 in_ready SHALL equal !p_valid || !stall; under the stall condition P holds its contents.
REQ-021 Non-last beat in A: acc <= acc_sum; cnt <= cnt+1, saturating at all-ones; ovf_sticky |= overflow.
REQ-022 Last beat in A: out_acc <= acc_sum; out_cnt <= cnt+1 (saturating); out_ovf <= ovf_sticky | overflow; out_valid <= 1; acc, cnt and ovf_sticky cleared to 0.
REQ-023 Overflow: operands have equal sign and the sum sign differs; the sum wraps modulo 2^ACC_W with no saturation.
REQ-024 Latency: a last beat accepted in cycle t SHALL produce out_valid=1 in cycle t+2 when no stall occurs.
REQ-025 Throughput: one beat per cycle when out_ready is held 1.
REQ-026 Result drained with no new last in A: out_valid <= 0 next cycle.
REQ-027 Result drained and a new last in A in the same cycle: out_valid stays 1 and out_* load the new result, with no bubble.
REQ-028 out_acc, out_cnt and out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 A single-beat dot product (in_last=1 on a first beat) SHALL produce out_cnt=1 and out_acc=product.

Reset
REQ-030 rst=1 SHALL clear immediately, independent of clk: p_valid, acc, cnt, ovf_sticky, out_valid, out_acc, out_cnt, out_ovf to 0, and set first to 1.
REQ-031 in_ready SHALL be 1 during and after reset; a partial dot product in flight at reset is discarded with no output.
REQ-032 The first beat accepted after rst deasserts SHALL start a new dot product.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Beats (3,4),(−5,6),(255,−128, last), out_ready=1 -> out_acc=−32658, out_cnt=3, out_ovf=0, at t+2 after the last.
- Single beat (−256,−128, last) -> out_acc=32768, out_cnt=1.
- ACC_W=18, four beats (−256,−128) with last on the fourth -> out_acc=−131072 (wrapped), out_ovf=1; the next dot product (1,1, last) -> out_ovf=0.
- Back-to-back single-beat lasts (1,1),(2,2),(3,3) with out_ready=0 for 5 cycles: in_ready=0 from the third cycle; after release the outputs are 1, 4, 9 in order, no loss or duplication.
- Reset asserted mid-sequence after 2 non-last beats, then (7,7, last) -> out_acc=49, out_cnt=1; all outputs 0 during rst.
- Random signed stream of 1000 beats with random last and random out_ready, checked against a reference-model sum modulo 2^ACC_W plus count and overflow.

Source files
------------

// File: rtl/mac_acc_int8.sv
// rtl/mac_acc_int8.sv - int8 multiply-accumulate with streaming dot-product results
//
// mul_int8: combinational signed 9b x 8b multiplier.
//   rs1     - signed activation (9b)
//   rs2     - signed weight (8b)
//   product - signed product (17b)
//
// mac_acc_int8: two-stage (P: product register, A: accumulate) dot-product engine.
//   clk, rst                      - clock, async active-high reset
//   in_valid/in_ready             - beat handshake
//   in_rs1, in_rs2, in_last       - operands and end-of-dot-product marker
//   out_valid/out_ready           - result handshake
//   out_acc, out_cnt, out_ovf     - result sum, beat count, sticky overflow

module mul_int8 (
  input  logic [8:0]  rs1,
  input  logic [7:0]  rs2,
  output logic [16:0] product
);

  logic [16:0] rs1_ext;
  logic [16:0] rs2_ext;

  // The full product always fits in 17 bits, so a truncated 17x17 multiply is exact.
  assign rs1_ext = {{8{rs1[8]}}, rs1};
  assign rs2_ext = {{9{rs2[7]}}, rs2};
  assign product = rs1_ext * rs2_ext;

endmodule

module mac_acc_int8 #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_rs1,
  input  logic [7:0]       in_rs2,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  logic [16:0]      mul_p;

  logic             p_valid;
  logic             p_last;
  logic [16:0]      p_prod;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;
  logic             first;

  logic             stall;
  logic             in_fire;
  logic             a_fire;

  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_base;

  mul_int8 u_mul (
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .product (mul_p)
  );

  // Only a last beat needs the output register, so only it can be blocked
  // by a result the consumer has not taken yet.
  assign stall    = p_last & out_valid & ~out_ready;
  assign in_ready = ~p_valid | ~stall;
  assign in_fire  = in_valid & in_ready;
  assign a_fire   = p_valid & ~stall;

  always_comb begin
    acc_base = first ? '0 : acc;
    cnt_base = first ? '0 : cnt;
    ovf_base = first ? 1'b0 : ovf_sticky;
    prod_ext = {{(ACC_W-17){p_prod[16]}}, p_prod};
    acc_sum  = acc_base + prod_ext;
    // Same-sign operands producing a different-sign sum means the true sum left the range.
    sum_ovf  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  // Stage P: product register; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_prod  <= '0;
    end else if (in_fire) begin
      p_valid <= 1'b1;
      p_last  <= in_last;
      p_prod  <= mul_p;
    end else if (a_fire) begin
      p_valid <= 1'b0;
    end
  end

  // Stage A: accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      first      <= 1'b1;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_cnt    <= '0;
      out_ovf    <= 1'b0;
    end else if (a_fire) begin
      if (p_last) begin
        // A draining result and a new one can swap in the same cycle: no bubble.
        out_acc    <= acc_sum;
        out_cnt    <= cnt_next;
        out_ovf    <= ovf_base | sum_ovf;
        out_valid  <= 1'b1;
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
        first      <= 1'b1;
      end else begin
        acc        <= acc_sum;
        cnt        <= cnt_next;
        ovf_sticky <= ovf_base | sum_ovf;
        first      <= 1'b0;
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acc_int8.sv
// tb/tb_mac_acc_int8.sv - randomized and directed self-checking bench for mac_acc_int8

module tb_mac_acc_int8;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_last;
  logic              out_ready;
  logic [8:0]        in_rs1;
  logic [7:0]        in_rs2;

  logic              in_ready;
  logic              out_valid;
  logic [31:0]       out_acc;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  logic              in_ready18;
  logic              out_valid18;
  logic [17:0]       out_acc18;
  logic [CNT_W-1:0]  out_cnt18;
  logic              out_ovf18;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_acc_int8 #(.ACC_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  mac_acc_int8 #(.ACC_W(18), .CNT_W(CNT_W)) dut18 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready18),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_last(in_last),
    .out_valid(out_valid18), .out_ready(out_ready),
    .out_acc(out_acc18), .out_cnt(out_cnt18), .out_ovf(out_ovf18)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: exact integer sums, range-checked and wrapped per width.
  typedef struct {
    longint acc;
    longint cnt;
    longint ovf;
  } res_t;

  res_t   q32[$];
  res_t   q18[$];
  longint m_s32, m_s18, m_o32, m_o18, m_cnt;
  bit     sb_on = 1'b0;

  function automatic longint wrap_w(input longint t, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = t & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  function automatic bit out_of_range(input longint t, input int w);
    longint half;
    half = longint'(1) << (w - 1);
    return (t >= half) || (t < -half);
  endfunction

  task automatic model_clear();
    m_s32 = 0; m_s18 = 0; m_o32 = 0; m_o18 = 0; m_cnt = 0;
    q32.delete();
    q18.delete();
  endtask

  task automatic model_beat(input int a, input int b, input bit last);
    longint p;
    res_t   r;
    p = longint'(a) * longint'(b);
    if (out_of_range(m_s32 + p, 32)) m_o32 = 1;
    if (out_of_range(m_s18 + p, 18)) m_o18 = 1;
    m_s32 = wrap_w(m_s32 + p, 32);
    m_s18 = wrap_w(m_s18 + p, 18);
    if (m_cnt < 65535) m_cnt = m_cnt + 1;
    if (last) begin
      r.acc = m_s32; r.cnt = m_cnt; r.ovf = m_o32; q32.push_back(r);
      r.acc = m_s18; r.cnt = m_cnt; r.ovf = m_o18; q18.push_back(r);
      m_s32 = 0; m_s18 = 0; m_o32 = 0; m_o18 = 0; m_cnt = 0;
    end
  endtask

  // Scoreboard / stability monitor, active during the random phase.
  bit     hold_prev = 1'b0;
  longint prev_acc, prev_cnt, prev_ovf, prev_acc18;

  task automatic mon_step();
    res_t r;
    if (!sb_on) begin
      hold_prev = 1'b0;
      return;
    end
    if (hold_prev) begin
      check("hold_acc", longint'($signed(out_acc)), prev_acc);
      check("hold_cnt", longint'(out_cnt), prev_cnt);
      check("hold_ovf", longint'(out_ovf), prev_ovf);
      check("hold_acc18", longint'($signed(out_acc18)), prev_acc18);
    end
    if (out_valid && out_ready) begin
      if (q32.size() == 0) check("sb32_extra_result", 1, 0);
      else begin
        r = q32.pop_front();
        check("sb32_acc", longint'($signed(out_acc)), r.acc);
        check("sb32_cnt", longint'(out_cnt), r.cnt);
        check("sb32_ovf", longint'(out_ovf), r.ovf);
      end
    end
    if (out_valid18 && out_ready) begin
      if (q18.size() == 0) check("sb18_extra_result", 1, 0);
      else begin
        r = q18.pop_front();
        check("sb18_acc", longint'($signed(out_acc18)), r.acc);
        check("sb18_cnt", longint'(out_cnt18), r.cnt);
        check("sb18_ovf", longint'(out_ovf18), r.ovf);
      end
    end
    hold_prev  = out_valid && !out_ready;
    prev_acc   = longint'($signed(out_acc));
    prev_cnt   = longint'(out_cnt);
    prev_ovf   = longint'(out_ovf);
    prev_acc18 = longint'($signed(out_acc18));
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic drive_beat(input int a, input int b, input bit last);
    bit acc_ok;
    acc_ok   = 1'b0;
    in_valid = 1'b1;
    in_rs1   = a[8:0];
    in_rs2   = b[7:0];
    in_last  = last;
    for (int k = 0; k < 100 && !acc_ok; k++) begin
      @(negedge clk);
      if (in_ready) acc_ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!acc_ok) check("drive_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input longint e32, input longint e18,
                               input longint ecnt, input longint eo32, input longint eo18);
    @(negedge clk);
    check({tag, "_not_early"}, longint'(out_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, longint'(out_valid), 1);
    check({tag, "_acc"}, longint'($signed(out_acc)), e32);
    check({tag, "_cnt"}, longint'(out_cnt), ecnt);
    check({tag, "_ovf"}, longint'(out_ovf), eo32);
    check({tag, "_valid18"}, longint'(out_valid18), 1);
    check({tag, "_acc18"}, longint'($signed(out_acc18)), e18);
    check({tag, "_ovf18"}, longint'(out_ovf18), eo18);
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_a();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -256;
    if (r == 1) return 255;
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  function automatic int pick_b();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -128;
    if (r == 1) return 127;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint got[$];
    bit     sent3;
    int     beats;
    int     cyc;
    int     a, b;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0;
    #3;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_acc", longint'(out_acc), 0);
    check("rst_out_cnt", longint'(out_cnt), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-beat dot product.
    drive_beat(3, 4, 1'b0);
    drive_beat(-5, 6, 1'b0);
    drive_beat(255, -128, 1'b1);
    expect_result("dot3", -32658, -32658, 3, 0, 0);

    // Single beat.
    drive_beat(-256, -128, 1'b1);
    expect_result("single", 32768, 32768, 1, 0, 0);

    // Wrap on the narrow accumulator.
    for (int i = 0; i < 4; i++) drive_beat(-256, -128, i == 3);
    expect_result("wrap", 131072, -131072, 4, 0, 1);
    drive_beat(1, 1, 1'b1);
    expect_result("after_wrap", 1, 1, 1, 0, 0);

    // Back-to-back single-beat lasts under backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_rs1 = 9'd1; in_rs2 = 8'd1;
    @(negedge clk); check("bp_ready_c1", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_rs1 = 9'd2; in_rs2 = 8'd2;
    @(negedge clk); check("bp_ready_c2", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_rs1 = 9'd3; in_rs2 = 8'd3;
    @(negedge clk); check("bp_ready_c3", longint'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_c4", longint'(in_ready), 0);
    check("bp_hold_acc_c4", longint'($signed(out_acc)), 1);
    @(posedge clk); #1;
    @(negedge clk); check("bp_ready_c5", longint'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    sent3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) got.push_back(longint'($signed(out_acc)));
      if (in_valid && in_ready) sent3 = 1'b1;
      @(posedge clk); #1;
      if (sent3) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    check("bp_result_count", longint'(got.size()), 3);
    if (got.size() == 3) begin
      check("bp_res0", got[0], 1);
      check("bp_res1", got[1], 4);
      check("bp_res2", got[2], 9);
    end

    // Reset in the middle of a dot product, with a result still pending.
    out_ready = 1'b0;
    drive_beat(2, 3, 1'b1);
    drive_beat(5, 5, 1'b0);
    drive_beat(6, 6, 1'b0);
    check("pre_rst_valid", longint'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_acc", longint'(out_acc), 0);
    check("mid_rst_out_cnt", longint'(out_cnt), 0);
    check("mid_rst_out_ovf", longint'(out_ovf), 0);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    check("mid_rst_in_ready_edge", longint'(in_ready), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    drive_beat(7, 7, 1'b1);
    expect_result("post_rst", 49, 49, 1, 0, 0);

    // Random stream against the reference model.
    model_clear();
    sb_on = 1'b1;
    beats = 0;
    cyc   = 0;
    while (beats < 1000 && cyc < 20000) begin
      a = pick_a();
      b = pick_b();
      in_valid  = ($urandom_range(0, 9) < 8);
      in_rs1    = a[8:0];
      in_rs2    = b[7:0];
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_beat(a, b, in_last);
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_beats", longint'(beats), 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_beat(1, 1, 1'b1);
    model_beat(1, 1, 1'b1);
    for (int k = 0; k < 40 && (q32.size() != 0 || q18.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    check("drain_q32", longint'(q32.size()), 0);
    check("drain_q18", longint'(q18.size()), 0);
    sb_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
